// File: rtl/axilite_script_host.sv
// Script-driven AXI4-Lite master: walks a combinational instruction ROM
// (END / WRITE / READ / POLL), drives one slave and latches a sticky verdict.
module axilite_script_host #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 6,
  parameter int POLL_LIMIT = 1024,
  parameter int TIMEOUT    = 256
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  output logic [PC_WIDTH-1:0]     script_pc,
  input  logic [1:0]              script_op,
  input  logic [ADDR_WIDTH-1:0]   script_addr,
  input  logic [DATA_WIDTH-1:0]   script_data,
  input  logic [DATA_WIDTH-1:0]   script_mask,
  output logic                    sys_success,
  output logic                    sys_fail,
  output logic [2:0]              fail_code,
  output logic [PC_WIDTH-1:0]     fail_pc,
  output logic                    ACLK,
  output logic                    ARESETn,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [2:0]              AWPROT,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    BVALID,
  output logic                    BREADY,
  input  logic [1:0]              BRESP,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [2:0]              ARPROT,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PCNT_W = $clog2(POLL_LIMIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_END   = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_PASS, S_FAIL
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, mask_q, mask_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [PCNT_W-1:0]     poll_q, poll_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d, b_done_q, b_done_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  success_q, success_d, fail_q, fail_d;
  logic [2:0]            fcode_q, fcode_d;
  logic [PC_WIDTH-1:0]   fpc_q, fpc_d;
  logic                  aresetn_q, aresetn_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic err, adv, tmo_inc;
  logic [2:0] err_code;

  assign aw_hs = awvalid_q & AWREADY;
  assign w_hs  = wvalid_q  & WREADY;
  assign b_hs  = bready_q  & BVALID;
  assign ar_hs = arvalid_q & ARREADY;
  assign r_hs  = rready_q  & RVALID;

  // Next-state, per-instruction bookkeeping and next registered outputs
  always_comb begin
    state_d   = state_q;   pc_d      = pc_q;      op_d     = op_q;
    addr_d    = addr_q;    data_d    = data_q;    mask_d   = mask_q;
    strb_d    = strb_q;    poll_d    = poll_q;    tmo_d    = tmo_q;
    aw_done_d = aw_done_q; w_done_d  = w_done_q;  b_done_d = b_done_q;
    bresp_d   = bresp_q;   success_d = success_q; fail_d   = fail_q;
    fcode_d   = fcode_q;   fpc_d     = fpc_q;     aresetn_d = 1'b1;
    err = 1'b0; err_code = 3'd0; adv = 1'b0; tmo_inc = 1'b0;

    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
        pc_d    = '0;
      end
      S_FETCH: begin
        op_d = script_op; addr_d = script_addr; data_d = script_data; mask_d = script_mask;
        for (int i = 0; i < STRB_W; i++) strb_d[i] = |script_mask[8*i +: 8];
        poll_d = '0; tmo_d = '0;
        aw_done_d = 1'b0; w_done_d = 1'b0; b_done_d = 1'b0;
        case (script_op)
          OP_END: begin
            state_d   = S_PASS;
            success_d = 1'b1;
          end
          OP_WRITE: state_d = S_WR_ADDR_DATA;
          default:  state_d = S_RD_ADDR;
        endcase
      end
      S_WR_ADDR_DATA: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // a slave may return B before the write address/data both complete
        if (b_hs) begin
          b_done_d = 1'b1;
          bresp_d  = BRESP;
        end
        if (aw_hs || w_hs || b_hs) tmo_d = '0;
        else                       tmo_inc = 1'b1;
        if (aw_done_d && w_done_d) begin
          tmo_d = '0;
          if (b_done_d) begin
            if (bresp_d != 2'd0) begin err = 1'b1; err_code = 3'd1; end
            else adv = 1'b1;
          end else begin
            state_d = S_WR_RESP;
          end
        end
      end
      S_WR_RESP: begin
        if (b_hs) begin
          if (BRESP != 2'd0) begin err = 1'b1; err_code = 3'd1; end
          else adv = 1'b1;
        end else tmo_inc = 1'b1;
      end
      S_RD_ADDR: begin
        if (ar_hs) begin
          state_d = S_RD_DATA;
          tmo_d   = '0;
        end else tmo_inc = 1'b1;
      end
      S_RD_DATA: begin
        if (r_hs) begin
          if (RRESP != 2'd0) begin
            err = 1'b1; err_code = 3'd2;
          end else if (((RDATA ^ data_q) & mask_q) == '0) begin
            adv = 1'b1;
          end else if (op_q == OP_READ) begin
            err = 1'b1; err_code = 3'd3;
          end else if (poll_q == PCNT_W'(POLL_LIMIT - 1)) begin
            err = 1'b1; err_code = 3'd4;
          end else begin
            poll_d  = poll_q + 1'b1;
            state_d = S_RD_ADDR;
            tmo_d   = '0;
          end
        end else tmo_inc = 1'b1;
      end
      default: ;  // PASS / FAIL hold until reset
    endcase

    // stalled handshake watchdog
    if (tmo_inc) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin err = 1'b1; err_code = 3'd5; end
      else tmo_d = tmo_q + 1'b1;
    end

    // step to next instruction; running off the end of the ROM is an error
    if (adv) begin
      if (pc_q == '1) begin err = 1'b1; err_code = 3'd6; end
      else begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    if (err) begin
      state_d = S_FAIL;
      fail_d  = 1'b1;
      fcode_d = err_code;
      fpc_d   = pc_q;
    end

    // channel controls follow the state being entered so they are registered
    awvalid_d = (state_d == S_WR_ADDR_DATA) && !aw_done_d;
    wvalid_d  = (state_d == S_WR_ADDR_DATA) && !w_done_d;
    bready_d  = (state_d == S_WR_ADDR_DATA) || (state_d == S_WR_RESP);
    arvalid_d = (state_d == S_RD_ADDR);
    rready_d  = (state_d == S_RD_ADDR) || (state_d == S_RD_DATA);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_RST;  pc_q <= '0;  op_q <= '0;  addr_q <= '0;
      data_q <= '0;  mask_q <= '0;  strb_q <= '0;  poll_q <= '0;  tmo_q <= '0;
      aw_done_q <= 1'b0;  w_done_q <= 1'b0;  b_done_q <= 1'b0;  bresp_q <= '0;
      awvalid_q <= 1'b0;  wvalid_q <= 1'b0;  bready_q <= 1'b0;
      arvalid_q <= 1'b0;  rready_q <= 1'b0;
      success_q <= 1'b0;  fail_q <= 1'b0;  fcode_q <= '0;  fpc_q <= '0;
      aresetn_q <= 1'b0;
    end else begin
      state_q <= state_d;  pc_q <= pc_d;  op_q <= op_d;  addr_q <= addr_d;
      data_q <= data_d;  mask_q <= mask_d;  strb_q <= strb_d;  poll_q <= poll_d;  tmo_q <= tmo_d;
      aw_done_q <= aw_done_d;  w_done_q <= w_done_d;  b_done_q <= b_done_d;  bresp_q <= bresp_d;
      awvalid_q <= awvalid_d;  wvalid_q <= wvalid_d;  bready_q <= bready_d;
      arvalid_q <= arvalid_d;  rready_q <= rready_d;
      success_q <= success_d;  fail_q <= fail_d;  fcode_q <= fcode_d;  fpc_q <= fpc_d;
      aresetn_q <= aresetn_d;
    end
  end

  assign ACLK        = sys_clk;
  assign ARESETn     = aresetn_q;
  assign script_pc   = pc_q;
  assign sys_success = success_q;
  assign sys_fail    = fail_q;
  assign fail_code   = fcode_q;
  assign fail_pc     = fpc_q;
  assign AWVALID     = awvalid_q;
  assign AWADDR      = addr_q;
  assign AWPROT      = 3'b000;
  assign WVALID      = wvalid_q;
  assign WDATA       = data_q;
  assign WSTRB       = strb_q;
  assign BREADY      = bready_q;
  assign ARVALID     = arvalid_q;
  assign ARADDR      = addr_q;
  assign ARPROT      = 3'b000;
  assign RREADY      = rready_q;
endmodule

// File: tb/tb_axilite_script_host.sv
// Directed bench: configurable AXI4-Lite slave model plus script ROM around the host.
module tb_axilite_script_host;
  localparam int AW = 8, DW = 32, PW = 4, PL = 4, TO = 16;

  logic          sys_clk = 1'b0, sys_rst = 1'b1;
  logic [PW-1:0] script_pc;
  logic [1:0]    script_op;
  logic [AW-1:0] script_addr;
  logic [DW-1:0] script_data, script_mask;
  logic          sys_success, sys_fail, ACLK, ARESETn;
  logic [2:0]    fail_code;
  logic [PW-1:0] fail_pc;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;

  always #5 sys_clk = ~sys_clk;

  axilite_script_host #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_WIDTH(PW),
                        .POLL_LIMIT(PL), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .script_pc(script_pc), .script_op(script_op),
    .script_addr(script_addr), .script_data(script_data), .script_mask(script_mask),
    .sys_success(sys_success), .sys_fail(sys_fail), .fail_code(fail_code), .fail_pc(fail_pc),
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP));

  // script ROM
  logic [1:0]  sc_op   [16];
  logic [7:0]  sc_addr [16];
  logic [31:0] sc_data [16];
  logic [31:0] sc_mask [16];
  assign script_op   = sc_op[script_pc];
  assign script_addr = sc_addr[script_pc];
  assign script_data = sc_data[script_pc];
  assign script_mask = sc_mask[script_pc];

  // slave configuration
  int          cfg_aw_wait, cfg_w_wait, cfg_ar_wait, cfg_poll_n;
  logic        cfg_b_early, cfg_poll;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_init [16];

  // slave state
  logic [31:0] mem [16];
  int          aw_cnt, w_cnt, ar_cnt, aw_n, w_n, b_n, ar_n, rd_cnt, viol;
  logic        aw_got, w_got, bv_q, rv_q, aw_pend, w_pend, ar_pend;
  logic [7:0]  awaddr_c, ca;
  logic [31:0] wdata_c, cd, rdata_q;
  logic [3:0]  wstrb_c, cs;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign AWREADY = (aw_cnt >= cfg_aw_wait);
  assign WREADY  = (w_cnt >= cfg_w_wait);
  assign ARREADY = (ar_cnt >= cfg_ar_wait);
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;
  assign BVALID = bv_q | (cfg_b_early & w_got & aw_hs);
  assign BRESP  = cfg_bresp;
  assign RVALID = rv_q;
  assign RDATA  = rdata_q;
  assign RRESP  = cfg_rresp;
  assign ca = aw_hs ? AWADDR : awaddr_c;
  assign cd = w_hs ? WDATA : wdata_c;
  assign cs = w_hs ? WSTRB : wstrb_c;

  // slave behaviour: programmable ready delays, optional early B, poll status source
  always @(posedge sys_clk) begin
    if (!ARESETn) begin
      mem <= cfg_init;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0;
      rd_cnt <= 0; viol <= 0; aw_got <= 0; w_got <= 0; bv_q <= 0; rv_q <= 0;
      aw_pend <= 0; w_pend <= 0; ar_pend <= 0; rdata_q <= 0;
      awaddr_c <= 0; wdata_c <= 0; wstrb_c <= 0;
    end else begin
      if (AWVALID && !AWREADY) aw_cnt <= aw_cnt + 1; else if (aw_hs) aw_cnt <= 0;
      if (WVALID && !WREADY)   w_cnt  <= w_cnt + 1;  else if (w_hs)  w_cnt  <= 0;
      if (ARVALID && !ARREADY) ar_cnt <= ar_cnt + 1; else if (ar_hs) ar_cnt <= 0;
      if (aw_hs) begin aw_got <= 1; awaddr_c <= AWADDR; aw_n <= aw_n + 1; end
      if (w_hs)  begin w_got <= 1; wdata_c <= WDATA; wstrb_c <= WSTRB; w_n <= w_n + 1; end
      if (!cfg_b_early && !bv_q && (aw_got || aw_hs) && (w_got || w_hs)) bv_q <= 1;
      if (b_hs) begin
        bv_q <= 0; aw_got <= 0; w_got <= 0; b_n <= b_n + 1;
        for (int i = 0; i < 4; i++) if (cs[i]) mem[ca[5:2]][8*i +: 8] <= cd[8*i +: 8];
      end
      if (ar_hs) begin
        rv_q <= 1; ar_n <= ar_n + 1; rd_cnt <= rd_cnt + 1;
        if (cfg_poll && ARADDR == 8'h08) rdata_q <= (rd_cnt + 1 >= cfg_poll_n) ? 32'h80 : 32'h0;
        else                             rdata_q <= mem[ARADDR[5:2]];
      end
      if (r_hs) rv_q <= 0;
      aw_pend <= AWVALID & ~AWREADY;
      w_pend  <= WVALID & ~WREADY;
      ar_pend <= ARVALID & ~ARREADY;
      if ((aw_pend && !AWVALID) || (w_pend && !WVALID) || (ar_pend && !ARVALID)) viol <= viol + 1;
    end
  end

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ins(input int i, input logic [1:0] op, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] m);
    sc_op[i] = op; sc_addr[i] = a; sc_data[i] = d; sc_mask[i] = m;
  endtask

  task automatic defaults();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_poll_n = 0;
    cfg_b_early = 0; cfg_poll = 0; cfg_bresp = 0; cfg_rresp = 0;
    for (int i = 0; i < 16; i++) begin
      cfg_init[i] = 32'h0;
      set_ins(i, 2'd0, 8'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  // releases reset and counts cycles from the first FETCH until a verdict
  task automatic run(output int cyc);
    int n = 0;
    logic done = 1'b0;
    sys_rst = 1'b0;
    while (!done && n < 400) begin
      @(posedge sys_clk); #1;
      n++;
      if (sys_success || sys_fail) done = 1'b1;
    end
    chk("run_done", {63'd0, done}, 64'd1);
    cyc = n - 1;
  endtask

  task automatic chk_verdict(input string tag, input logic ok, input logic [2:0] code,
                             input logic [3:0] pc, input int cyc, input int exp_cyc);
    chk({tag, "_verdict"}, {sys_success, sys_fail}, {ok, ~ok});
    chk({tag, "_code"}, fail_code, code);
    chk({tag, "_pc"}, fail_pc, pc);
    chk({tag, "_cycle"}, cyc, exp_cyc);
    chk({tag, "_idle"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
  endtask

  initial begin
    int cyc, k;
    // basic write / read-back / end
    defaults();
    set_ins(0, 2'd1, 8'h04, 32'hDEADBEEF, 32'hFFFFFFFF);
    set_ins(1, 2'd2, 8'h04, 32'hDEADBEEF, 32'hFFFFFFFF);
    do_reset();
    chk("rst_axi", {AWVALID, WVALID, BREADY, ARVALID, RREADY, ARESETn}, 6'b0);
    chk("rst_stat", {sys_success, sys_fail, fail_code, fail_pc, script_pc}, 13'b0);
    run(cyc);
    chk_verdict("basic", 1'b1, 3'd0, 4'd0, cyc, 7);
    chk("basic_mem", mem[1], 32'hDEADBEEF);
    chk("basic_viol", viol, 0);

    // W accepted 3 cycles ahead of AW, B on the AW cycle, partial strobe
    defaults();
    cfg_aw_wait = 3; cfg_b_early = 1;
    cfg_init[4] = 32'hAAAAAAAA;
    set_ins(0, 2'd1, 8'h10, 32'h12345678, 32'h0000FFFF);
    set_ins(1, 2'd2, 8'h10, 32'hAAAA5678, 32'hFFFFFFFF);
    do_reset();
    run(cyc);
    chk_verdict("earlyb", 1'b1, 3'd0, 4'd0, cyc, 9);
    chk("earlyb_cnt", {aw_n[7:0], w_n[7:0], b_n[7:0]}, 24'h010101);
    chk("earlyb_strb", wstrb_c, 4'b0011);
    chk("earlyb_mem", mem[4], 32'hAAAA5678);
    chk("earlyb_viol", viol, 0);

    // read mismatch under mask
    defaults();
    cfg_init[3] = 32'hFFFFFFFE;
    set_ins(0, 2'd2, 8'h0C, 32'h1, 32'h1);
    do_reset();
    run(cyc);
    chk_verdict("rdmis", 1'b0, 3'd3, 4'd0, cyc, 3);

    // poll: status appears on the 4th read, exactly at POLL_LIMIT
    defaults();
    cfg_poll = 1; cfg_poll_n = 4;
    set_ins(0, 2'd3, 8'h08, 32'h80, 32'h80);
    do_reset();
    run(cyc);
    chk_verdict("pollok", 1'b1, 3'd0, 4'd0, cyc, 10);
    chk("pollok_reads", ar_n, 4);

    // poll: status on the 5th read, one past the limit
    defaults();
    cfg_poll = 1; cfg_poll_n = 5;
    set_ins(0, 2'd3, 8'h08, 32'h80, 32'h80);
    do_reset();
    run(cyc);
    chk_verdict("pollfail", 1'b0, 3'd4, 4'd0, cyc, 9);
    chk("pollfail_reads", ar_n, 4);

    // AWREADY never rises; W handshake on the first wait cycle clears the watchdog
    defaults();
    cfg_aw_wait = 100000;
    set_ins(0, 2'd1, 8'h04, 32'h1, 32'hFFFFFFFF);
    do_reset();
    run(cyc);
    chk_verdict("tmo", 1'b0, 3'd5, 4'd0, cyc, 2 + TO);

    // error write response on the second instruction
    defaults();
    cfg_bresp = 2'd2;
    set_ins(0, 2'd2, 8'h04, 32'h0, 32'hFFFFFFFF);
    set_ins(1, 2'd1, 8'h04, 32'h5, 32'hFFFFFFFF);
    do_reset();
    run(cyc);
    chk_verdict("bresp", 1'b0, 3'd1, 4'd1, cyc, 6);

    // error read response
    defaults();
    cfg_rresp = 2'd2;
    set_ins(0, 2'd2, 8'h04, 32'h0, 32'h0);
    do_reset();
    run(cyc);
    chk_verdict("rresp", 1'b0, 3'd2, 4'd0, cyc, 3);

    // script of 16 reads with no END runs off the ROM
    defaults();
    for (int i = 0; i < 16; i++) set_ins(i, 2'd2, 8'h04, 32'h0, 32'h0);
    do_reset();
    run(cyc);
    chk_verdict("pcovf", 1'b0, 3'd6, 4'd15, cyc, 48);

    // reset while ARVALID is waiting, then a clean rerun
    defaults();
    cfg_ar_wait = 100000;
    set_ins(0, 2'd1, 8'h04, 32'hDEADBEEF, 32'hFFFFFFFF);
    set_ins(1, 2'd2, 8'h04, 32'hDEADBEEF, 32'hFFFFFFFF);
    do_reset();
    sys_rst = 1'b0;
    k = 0;
    while (!ARVALID && k < 50) begin @(posedge sys_clk); #1; k++; end
    chk("mid_arvalid_seen", {63'd0, ARVALID}, 64'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    chk("mid_drop", {ARVALID, RREADY, ARESETn}, 3'b000);
    chk("mid_pc", script_pc, 4'd0);
    cfg_ar_wait = 0;
    do_reset();
    run(cyc);
    chk_verdict("mid_rerun", 1'b1, 3'd0, 4'd0, cyc, 7);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
